// File: rtl/sme_pkg.sv
// Shared constants, FSM encoding and case-fold helper for the string-match engine.
package sme_pkg;

  localparam logic [7:0] CH_HAT    = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_S,
    LOAD_P,
    SEARCH,
    DONE
  } state_e;

  // Map A-Z onto a-z; every other code passes through unchanged.
  function automatic logic [7:0] fold_ch(input logic [7:0] c);
    fold_ch = ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
  endfunction

endpackage

// File: rtl/sme_cmp_lane.sv
// One body-character comparison: wildcard, optional case fold, disabled lanes pass.
module sme_cmp_lane
  import sme_pkg::*;
(
  input  logic       en,
  input  logic [7:0] pat_ch,
  input  logic [7:0] str_ch,
  input  logic       fold,
  output logic       ok_c
);

  always_comb begin
    ok_c = 1'b1;
    if (en && (pat_ch != CH_DOT)) begin
      if (fold) ok_c = (fold_ch(pat_ch) == fold_ch(str_ch));
      else      ok_c = (pat_ch == str_ch);
    end
  end

endmodule

// File: rtl/sme_param.sv
// Parametrised string-match engine: loads a string and patterns, then scans one
// candidate start index per cycle with all body characters compared in parallel.
module sme_param
  import sme_pkg::*;
#(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned IDX_W   = $clog2(STR_MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  input  logic             case_fold,
  output logic             busy,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index
);

  localparam int unsigned LW  = $clog2(STR_MAX + 1);
  localparam int unsigned PW  = $clog2(PAT_MAX + 1);
  localparam int unsigned CW  = ((LW > PW) ? LW : PW) + 1;
  localparam int unsigned SAW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int unsigned PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  state_e        state_q, state_d;
  logic [7:0]    str_q [STR_MAX];
  logic [7:0]    pat_q [PAT_MAX];
  logic [LW-1:0] len_s_q;
  logic [PW-1:0] len_p_q;
  logic          fold_q;
  logic          isstring_q;
  logic [CW-1:0] idx_q;

  logic          str_first_c, str_wr_c, pat_first_c, pat_wr_c;
  logic          hat_c, dollar_c, degen_c, last_c, hit_c, term_c;
  logic          hat_ok_c, dollar_ok_c;
  logic [CW-1:0] body_len_c, len_s_c, end_pos_c;
  logic [PAT_MAX-1:0] lane_ok_c;

  // A string burst starts from IDLE or when isstring re-rises while still loading.
  assign str_first_c = isstring && ((state_q == IDLE) || ((state_q == LOAD_S) && !isstring_q));
  assign str_wr_c    = isstring && ((state_q == IDLE) || (state_q == LOAD_S));
  assign pat_first_c = ispattern && !isstring && ((state_q == IDLE) || (state_q == LOAD_S));
  assign pat_wr_c    = ispattern && (state_q == LOAD_P);

  // Anchors are recognised only at the pattern ends; body length excludes them.
  assign hat_c      = (len_p_q != '0) && (pat_q[0] == CH_HAT);
  assign dollar_c   = (len_p_q != '0) && (pat_q[PAW'(len_p_q - PW'(1))] == CH_DOLLAR);
  assign body_len_c = CW'(len_p_q) - CW'(hat_c) - CW'(dollar_c);
  assign len_s_c    = CW'(len_s_q);
  assign degen_c    = (body_len_c == '0) || (body_len_c > len_s_c);
  assign last_c     = (idx_q == (len_s_c - body_len_c));
  assign end_pos_c  = idx_q + body_len_c;

  for (genvar k = 0; k < PAT_MAX; k++) begin : g_lane
    logic [CW-1:0] ppos_c, spos_c;
    logic [7:0]    pch_c, sch_c;
    assign ppos_c = CW'(k) + CW'(hat_c);
    assign spos_c = idx_q + CW'(k);
    assign pch_c  = (ppos_c < CW'(PAT_MAX)) ? pat_q[PAW'(ppos_c)] : 8'h00;
    assign sch_c  = (spos_c < CW'(STR_MAX)) ? str_q[SAW'(spos_c)] : 8'h00;
    sme_cmp_lane u_lane (
      .en     (CW'(k) < body_len_c),
      .pat_ch (pch_c),
      .str_ch (sch_c),
      .fold   (fold_q),
      .ok_c   (lane_ok_c[k])
    );
  end

  assign hat_ok_c    = !hat_c || (idx_q == '0) || (str_q[SAW'(idx_q - CW'(1))] == CH_SPACE);
  assign dollar_ok_c = !dollar_c || (end_pos_c == len_s_c) ||
                       ((end_pos_c < CW'(STR_MAX)) && (str_q[SAW'(end_pos_c)] == CH_SPACE));
  assign hit_c       = !degen_c && (&lane_ok_c) && hat_ok_c && dollar_ok_c;
  assign term_c      = degen_c || hit_c || last_c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (isstring)       state_d = LOAD_S;
        else if (ispattern) state_d = LOAD_P;
      end
      LOAD_S:  if (ispattern) state_d = LOAD_P;
      LOAD_P:  if (!ispattern) state_d = SEARCH;
      SEARCH:  if (term_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // String and pattern storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_q      <= '{default: '0};
      pat_q      <= '{default: '0};
      len_s_q    <= '0;
      len_p_q    <= '0;
      fold_q     <= 1'b0;
      isstring_q <= 1'b0;
    end else begin
      isstring_q <= isstring;
      if (str_first_c) begin
        str_q    <= '{default: '0};
        str_q[0] <= chardata;
        len_s_q  <= LW'(1);
      end else if (str_wr_c && (len_s_q < LW'(STR_MAX))) begin
        str_q[SAW'(len_s_q)] <= chardata;
        len_s_q              <= len_s_q + LW'(1);
      end
      if (pat_first_c) begin
        pat_q[0] <= chardata;
        len_p_q  <= PW'(1);
        fold_q   <= case_fold;
      end else if (pat_wr_c && (len_p_q < PW'(PAT_MAX))) begin
        pat_q[PAW'(len_p_q)] <= chardata;
        len_p_q              <= len_p_q + PW'(1);
      end
    end
  end

  // Candidate counter, result capture and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
    end else begin
      busy  <= (state_d == SEARCH) || (state_d == DONE);
      valid <= (state_d == DONE);
      if (state_q != SEARCH) idx_q <= '0;
      else if (!term_c)      idx_q <= idx_q + CW'(1);
      if ((state_q == SEARCH) && term_c) begin
        match       <= hit_c;
        match_index <= hit_c ? IDX_W'(idx_q) : '0;
      end
    end
  end

endmodule

// File: tb/tb_sme_param.sv
// Scoreboard bench for sme_param: directed and random string/pattern transactions.
module tb_sme_param;

  localparam int unsigned STR_MAX = 32;
  localparam int unsigned PAT_MAX = 8;
  localparam int unsigned IDX_W   = 5;

  logic             clk;
  logic             reset;
  logic [7:0]       chardata;
  logic             isstring;
  logic             ispattern;
  logic             case_fold;
  logic             busy;
  logic             valid;
  logic             match;
  logic [IDX_W-1:0] match_index;

  sme_param #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .case_fold   (case_fold),
    .busy        (busy),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     m;
    int     idx;
    longint cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] ms[$];
  logic [7:0] mp[$];
  logic [7:0] tx_q[$];
  logic [7:0] salpha [5];
  logic [7:0] palpha [8];
  longint     cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lower(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'd32;
    return c;
  endfunction

  function automatic bit ceq(input logic [7:0] p, input logic [7:0] c, input bit fold);
    if (p == 8'h2E) return 1'b1;
    if (fold) return lower(p) == lower(c);
    return p == c;
  endfunction

  // Reference: scan start positions in order, first hit wins; latency is 2 + last i tried.
  function automatic void ref_model(input bit fold, output bit m, output int idx, output int lat);
    int L, P, B, hs;
    bit hat, dol, ok;
    L   = ms.size();
    P   = mp.size();
    hat = (P > 0) && (mp[0] == 8'h5E);
    dol = (P > 0) && (mp[P-1] == 8'h24);
    hs  = hat ? 1 : 0;
    B   = P - hs - (dol ? 1 : 0);
    m   = 1'b0;
    idx = 0;
    lat = 2;
    if (B <= 0 || B > L) return;
    for (int i = 0; i <= L - B; i++) begin
      lat = 2 + i;
      ok  = 1'b1;
      for (int k = 0; k < B; k++)
        if (!ceq(mp[hs+k], ms[i+k], fold)) ok = 1'b0;
      if (hat && i != 0 && ms[i-1] != 8'h20) ok = 1'b0;
      if (dol && i + B != L && ms[i+B] != 8'h20) ok = 1'b0;
      if (ok) begin
        m   = 1'b1;
        idx = i;
        return;
      end
    end
  endfunction

  task automatic set_tx(input string s);
    tx_q.delete();
    for (int k = 0; k < s.len(); k++) tx_q.push_back(s[k]);
  endtask

  task automatic load_string();
    ms.delete();
    foreach (tx_q[k]) if (ms.size() < STR_MAX) ms.push_back(tx_q[k]);
    foreach (tx_q[k]) begin
      chardata = tx_q[k];
      isstring = 1'b1;
      @(negedge clk);
    end
    isstring = 1'b0;
  endtask

  // case_fold is inverted after the first char: only the first char's value must count.
  task automatic send_pattern(input bit fold, input bit expect_result);
    longint t;
    bit     m;
    int     idx, lat;
    exp_t   e;
    mp.delete();
    foreach (tx_q[k]) if (mp.size() < PAT_MAX) mp.push_back(tx_q[k]);
    foreach (tx_q[k]) begin
      chardata  = tx_q[k];
      ispattern = 1'b1;
      case_fold = (k == 0) ? fold : !fold;
      @(negedge clk);
    end
    ispattern = 1'b0;
    chardata  = 8'h00;
    t = cyc;
    ref_model(fold, m, idx, lat);
    e.m   = m;
    e.idx = idx;
    e.cyc = t + lat;
    if (expect_result) exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    @(negedge clk);
    check("busy_rise", busy, 1);
    n = 0;
    while (busy && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: busy=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic run(input string p, input bit fold);
    set_tx(p);
    send_pattern(fold, 1'b1);
    wait_idle();
  endtask

  // Monitor: every valid strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: valid=1 at cycle %0d, required no strobe", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("match", match, mon_e.m);
        check("match_index", match_index, mon_e.idx);
        check("valid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    int n;
    salpha = '{8'h61, 8'h62, 8'h41, 8'h42, 8'h20};
    palpha = '{8'h61, 8'h62, 8'h41, 8'h42, 8'h20, 8'h2E, 8'h5E, 8'h24};
    reset = 1'b0; isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00; case_fold = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_match", match, 0);
    check("reset_index", match_index, 0);
    reset = 1'b1;
    @(negedge clk);

    set_tx("hello world");
    load_string();
    run("wor", 1'b0);
    run("^wor", 1'b0);
    run("^orl", 1'b0);
    run("lo$", 1'b0);
    run("ld$", 1'b0);
    run("hel$", 1'b0);
    run("W.R", 1'b1);
    run("W.R", 1'b0);
    run("^", 1'b0);

    set_tx("abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMN");
    load_string();
    run("HIJ", 1'b0);
    run("ABC", 1'b0);

    // Abort a long search with reset; no strobe may follow.
    tx_q.delete();
    repeat (32) tx_q.push_back(8'h61);
    load_string();
    set_tx("b");
    send_pattern(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("abort_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ms.delete();
    @(negedge clk);
    run("a", 1'b0);
    set_tx("hello world");
    load_string();
    run("wor", 1'b0);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        tx_q.delete();
        n = $urandom_range(1, 40);
        for (int k = 0; k < n; k++) tx_q.push_back(salpha[$urandom_range(0, 4)]);
        load_string();
      end
      tx_q.delete();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) tx_q.push_back(palpha[$urandom_range(0, 7)]);
      send_pattern(1'($urandom_range(0, 1)), 1'b1);
      wait_idle();
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sme_param.md
Name: sme_param

Overview:
- Parametrised string-match engine; successor to the fixed 32-char / 8-char matcher.
- Loads one string, then one or more patterns, over a shared byte stream. For each pattern it reports whether the pattern occurs in the string and the lowest start index of the match.
- Supports anchors '^' (start of word) and '$' (end of word), and wildcard '.' (any one character).
- New behaviour: configurable depths, optional case-insensitive compare, and an explicit busy output.

Parameters:
STR_MAX, 32, max stored string length; chars beyond it are ignored
PAT_MAX, 8, max stored pattern chars including anchors; chars beyond it are ignored
IDX_W, $clog2(STR_MAX), width of match_index

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
chardata  in  8  ASCII character, valid when isstring or ispattern is high
isstring  in  1  high for consecutive cycles while string chars are presented
ispattern  in  1  high for consecutive cycles while pattern chars are presented
case_fold  in  1  sampled on the first pattern char; 1 = A-Z equal to a-z
busy  out  1  high from the cycle after the last pattern char through the valid cycle
valid  out  1  one-cycle result strobe
match  out  1  result, qualified by valid
match_index  out  IDX_W  lowest match start index, qualified by valid; 0 when match=0

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; string length L=0, pattern length P=0; busy, valid, match, match_index all 0. Reset during SEARCH aborts the search; no valid is issued.
- States:
  - IDLE->LOAD_S on isstring.
  - LOAD_S->LOAD_P on ispattern.
  - LOAD_P->SEARCH when ispattern falls.
  - SEARCH->DONE on termination.
  - DONE->IDLE (valid=1 here, one cycle).
  - IDLE->LOAD_P on ispattern: the stored string is reused.
- Loading:
  - A new isstring burst clears L and the stored string.
  - A new ispattern burst clears P.
  - Writes go to index L or P, which then increments and saturates at STR_MAX or PAT_MAX.
  - isstring and ispattern are never high together. Host drives neither while busy=1; such input is ignored.
- Pattern parse:
  - '^' (0x5E) is an anchor only at pattern position 0.
  - '$' (0x24) is an anchor only at position P-1.
  - Anywhere else, both are literal characters.
  - Body = remaining chars, length B.
  - '.' (0x2E) in the body matches any char, including space.
- Match rule at start index i:
  - i+B <= L, and every body char equals s[i+k] (case-folded if case_fold).
  - '^' additionally requires i==0 or s[i-1]==0x20.
  - '$' additionally requires i+B==L or s[i+B]==0x20.
- Search timing:
  - Last pattern char at cycle T; SEARCH starts at T+1.
  - One candidate i per cycle (i = 0,1,...), all PAT_MAX body comparisons in parallel.
  - Terminates at the first hit, or after evaluating i=L-B.
  - valid is high in the cycle after the terminating SEARCH cycle, i.e. cycle T+2+i_last.
- Degenerate cases:
  - B==0 or B>L: a single SEARCH cycle, then valid with match=0 at T+2.
  - L==0 is handled as B>L.
- case_fold affects only letters; digits, space and punctuation compare exactly.
- busy falls in the cycle after valid. A new ispattern or isstring burst is accepted in that cycle.

Decomposition:
- Package sme_pkg holds:
  - char constants CH_HAT=0x5E, CH_DOLLAR=0x24, CH_DOT=0x2E, CH_SPACE=0x20;
  - the state enum {IDLE, LOAD_S, LOAD_P, SEARCH, DONE};
  - a fold function (A-Z to a-z).
- Sub-module sme_cmp_lane: one body-char compare (wildcard + fold), instantiated PAT_MAX times by generate.

Test Plan:
- String "hello world" (L=11), pattern "wor", fold=0 -> valid at T+8, match=1, match_index=6.
- Same string, "^wor" -> match=1, idx 6. Same string, "^orl" -> match=0, idx 0, valid at T+10 (L-B=8).
- Same string, "lo$" -> match=1, idx 3 (s[5] is space). "ld$" -> match=1, idx 9. "hel$" -> match=0.
- Pattern "W.R": fold=1 -> match=1, idx 6. fold=0 -> match=0. Pattern "^" alone -> match=0 at T+2.
- 40-char string with STR_MAX=32 -> L=32, chars 32..39 dropped. Pattern matching only chars 33-35 -> match=0. Two back-to-back patterns without a new string -> both searched against the stored string.
- reset pulled low during SEARCH -> busy and valid go 0 immediately with no valid strobe. The next string/pattern transaction completes normally.
